// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer for the single-bus datapath.
// Only the state register is storage; every strobe is a decode of state, opcode and con_ff.
module control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic        run,
  output logic        read,
  output logic        write,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        Cout,
  output logic        IN_Portout,
  output logic        LOout,
  output logic        HIout,
  output logic        BAout,
  output logic        Rout,
  output logic        MARIn,
  output logic        PCIn,
  output logic        MDRIn,
  output logic        IRIn,
  output logic        YIn,
  output logic        IncPC,
  output logic        HiIn,
  output logic        LoIn,
  output logic        CIn,
  output logic        InIn,
  output logic        OutIn,
  output logic        ZIn,
  output logic        CONIn,
  output logic        RIn,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        add,
  output logic        subtract,
  output logic        multiply,
  output logic        divide,
  output logic        andSignal,
  output logic        orSignal
);

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10010;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b10111;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [OP_W-1:0] w_op;
  logic            w_is_add;
  logic            w_is_sub;
  logic            w_is_and;
  logic            w_is_or;
  logic            w_is_mul;
  logic            w_is_div;
  logic            w_is_alu;
  logic            w_is_muldiv;
  logic            w_is_ld;
  logic            w_is_br;
  logic            w_is_mfhi;
  logic            w_is_mflo;
  logic            w_is_halt;
  logic            w_unused_ir;

  // Opcode classification; anything unrecognised falls through to nop behaviour.
  assign w_op        = ir[31:27];
  assign w_unused_ir = ^ir[26:0];
  assign w_is_add    = (w_op == OP_ADD);
  assign w_is_sub    = (w_op == OP_SUB);
  assign w_is_and    = (w_op == OP_AND);
  assign w_is_or     = (w_op == OP_OR);
  assign w_is_mul    = (w_op == OP_MUL);
  assign w_is_div    = (w_op == OP_DIV);
  assign w_is_ld     = (w_op == OP_LD);
  assign w_is_br     = (w_op == OP_BR);
  assign w_is_mfhi   = (w_op == OP_MFHI);
  assign w_is_mflo   = (w_op == OP_MFLO);
  assign w_is_halt   = (w_op == OP_HALT);
  assign w_is_alu    = w_is_add | w_is_sub | w_is_and | w_is_or;
  assign w_is_muldiv = w_is_mul | w_is_div;

  // Strobes this sequencer never drives.
  assign write      = 1'b0;
  assign CIn        = 1'b0;
  assign InIn       = 1'b0;
  assign OutIn      = 1'b0;
  assign IN_Portout = 1'b0;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= S_RESET;
    else     r_state <= w_next;
  end

  // Next state: instruction length is set by which T-state hands back to T0.
  always_comb begin
    w_next = S_RESET;
    case (r_state)
      S_RESET: w_next = S_T0;
      S_T0:    w_next = S_T1;
      S_T1:    w_next = S_T2;
      S_T2:    w_next = S_T3;
      S_T3: begin
        if (w_is_halt)                                  w_next = S_HALT;
        else if (w_is_alu | w_is_muldiv | w_is_ld | w_is_br) w_next = S_T4;
        else                                            w_next = S_T0;
      end
      S_T4: begin
        if (w_is_alu | w_is_muldiv | w_is_ld | w_is_br) w_next = S_T5;
        else                                            w_next = S_T0;
      end
      S_T5: begin
        if (w_is_muldiv | w_is_ld | w_is_br) w_next = S_T6;
        else                                 w_next = S_T0;
      end
      S_T6: begin
        if (w_is_ld) w_next = S_T7;
        else         w_next = S_T0;
      end
      S_T7:    w_next = S_T0;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_RESET;
    endcase
  end

  // Strobe decode: every output defaults low and is raised only by its state.
  always_comb begin
    run       = 1'b0;
    read      = 1'b0;
    PCout     = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    MDRout    = 1'b0;
    Cout      = 1'b0;
    LOout     = 1'b0;
    HIout     = 1'b0;
    BAout     = 1'b0;
    Rout      = 1'b0;
    MARIn     = 1'b0;
    PCIn      = 1'b0;
    MDRIn     = 1'b0;
    IRIn      = 1'b0;
    YIn       = 1'b0;
    IncPC     = 1'b0;
    HiIn      = 1'b0;
    LoIn      = 1'b0;
    ZIn       = 1'b0;
    CONIn     = 1'b0;
    RIn       = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    add       = 1'b0;
    subtract  = 1'b0;
    multiply  = 1'b0;
    divide    = 1'b0;
    andSignal = 1'b0;
    orSignal  = 1'b0;
    case (r_state)
      S_T0: begin
        run   = 1'b1;
        PCout = 1'b1;
        MARIn = 1'b1;
        IncPC = 1'b1;
        ZIn   = 1'b1;
      end
      S_T1: begin
        run     = 1'b1;
        Zlowout = 1'b1;
        PCIn    = 1'b1;
        read    = 1'b1;
        MDRIn   = 1'b1;
      end
      S_T2: begin
        run    = 1'b1;
        MDRout = 1'b1;
        IRIn   = 1'b1;
      end
      S_T3: begin
        run = 1'b1;
        if (w_is_alu) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          YIn  = 1'b1;
        end else if (w_is_muldiv) begin
          Gra  = 1'b1;
          Rout = 1'b1;
          YIn  = 1'b1;
        end else if (w_is_mfhi) begin
          HIout = 1'b1;
          Gra   = 1'b1;
          RIn   = 1'b1;
        end else if (w_is_mflo) begin
          LOout = 1'b1;
          Gra   = 1'b1;
          RIn   = 1'b1;
        end else if (w_is_ld) begin
          Grb   = 1'b1;
          BAout = 1'b1;
          YIn   = 1'b1;
        end else if (w_is_br) begin
          Gra   = 1'b1;
          Rout  = 1'b1;
          CONIn = 1'b1;
        end
      end
      S_T4: begin
        run = 1'b1;
        if (w_is_alu) begin
          Grc       = 1'b1;
          Rout      = 1'b1;
          ZIn       = 1'b1;
          add       = w_is_add;
          subtract  = w_is_sub;
          andSignal = w_is_and;
          orSignal  = w_is_or;
        end else if (w_is_muldiv) begin
          Grb      = 1'b1;
          Rout     = 1'b1;
          ZIn      = 1'b1;
          multiply = w_is_mul;
          divide   = w_is_div;
        end else if (w_is_ld) begin
          Cout = 1'b1;
          add  = 1'b1;
          ZIn  = 1'b1;
        end else if (w_is_br) begin
          PCout = 1'b1;
          YIn   = 1'b1;
        end
      end
      S_T5: begin
        run = 1'b1;
        if (w_is_alu) begin
          Zlowout = 1'b1;
          Gra     = 1'b1;
          RIn     = 1'b1;
        end else if (w_is_muldiv) begin
          Zlowout = 1'b1;
          LoIn    = 1'b1;
        end else if (w_is_ld) begin
          Zlowout = 1'b1;
          MARIn   = 1'b1;
        end else if (w_is_br) begin
          Cout = 1'b1;
          add  = 1'b1;
          ZIn  = 1'b1;
        end
      end
      S_T6: begin
        run = 1'b1;
        if (w_is_muldiv) begin
          Zhighout = 1'b1;
          HiIn     = 1'b1;
        end else if (w_is_ld) begin
          read  = 1'b1;
          MDRIn = 1'b1;
        end else if (w_is_br) begin
          Zlowout = 1'b1;
          PCIn    = con_ff;
        end
      end
      S_T7: begin
        run = 1'b1;
        if (w_is_ld) begin
          MDRout = 1'b1;
          Gra    = 1'b1;
          RIn    = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Table-driven check of the control sequencer: per-cycle expected strobe words are queued
// as stimulus is driven and compared at the following falling edge.
module tb_control_unit;

  localparam logic [35:0] M_RUN   = 36'h1 << 0;
  localparam logic [35:0] M_READ  = 36'h1 << 1;
  localparam logic [35:0] M_PCOUT = 36'h1 << 3;
  localparam logic [35:0] M_ZLOW  = 36'h1 << 4;
  localparam logic [35:0] M_ZHIGH = 36'h1 << 5;
  localparam logic [35:0] M_MDROUT= 36'h1 << 6;
  localparam logic [35:0] M_COUT  = 36'h1 << 7;
  localparam logic [35:0] M_LOOUT = 36'h1 << 9;
  localparam logic [35:0] M_HIOUT = 36'h1 << 10;
  localparam logic [35:0] M_BAOUT = 36'h1 << 11;
  localparam logic [35:0] M_ROUT  = 36'h1 << 12;
  localparam logic [35:0] M_MARIN = 36'h1 << 13;
  localparam logic [35:0] M_PCIN  = 36'h1 << 14;
  localparam logic [35:0] M_MDRIN = 36'h1 << 15;
  localparam logic [35:0] M_IRIN  = 36'h1 << 16;
  localparam logic [35:0] M_YIN   = 36'h1 << 17;
  localparam logic [35:0] M_INCPC = 36'h1 << 18;
  localparam logic [35:0] M_HIIN  = 36'h1 << 19;
  localparam logic [35:0] M_LOIN  = 36'h1 << 20;
  localparam logic [35:0] M_ZIN   = 36'h1 << 24;
  localparam logic [35:0] M_CONIN = 36'h1 << 25;
  localparam logic [35:0] M_RIN   = 36'h1 << 26;
  localparam logic [35:0] M_GRA   = 36'h1 << 27;
  localparam logic [35:0] M_GRB   = 36'h1 << 28;
  localparam logic [35:0] M_GRC   = 36'h1 << 29;
  localparam logic [35:0] M_ADD   = 36'h1 << 30;
  localparam logic [35:0] M_SUB   = 36'h1 << 31;
  localparam logic [35:0] M_MUL   = 36'h1 << 32;
  localparam logic [35:0] M_DIV   = 36'h1 << 33;
  localparam logic [35:0] M_AND   = 36'h1 << 34;
  localparam logic [35:0] M_OR    = 36'h1 << 35;

  localparam logic [35:0] F0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
  localparam logic [35:0] F1 = M_RUN | M_ZLOW | M_PCIN | M_READ | M_MDRIN;
  localparam logic [35:0] F2 = M_RUN | M_MDROUT | M_IRIN;

  typedef struct packed {
    logic [31:0]      ir;
    logic             con;
    logic [3:0]       len;
    logic [4:0][35:0] tail;
  } vec_t;

  logic clk = 1'b0;
  logic clr;
  logic [31:0] ir;
  logic con_ff;
  logic run, read, write, PCout, Zlowout, Zhighout, MDRout, Cout, IN_Portout, LOout, HIout;
  logic BAout, Rout, MARIn, PCIn, MDRIn, IRIn, YIn, IncPC, HiIn, LoIn, CIn, InIn, OutIn, ZIn;
  logic CONIn, RIn, Gra, Grb, Grc, add, subtract, multiply, divide, andSignal, orSignal;
  logic [35:0] w_obs;

  int total = 0;
  int bad = 0;
  logic [35:0] exp_q[$];
  string tag_q[$];
  vec_t vecs[13];

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff),
    .run(run), .read(read), .write(write), .PCout(PCout), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .MDRout(MDRout), .Cout(Cout), .IN_Portout(IN_Portout),
    .LOout(LOout), .HIout(HIout), .BAout(BAout), .Rout(Rout), .MARIn(MARIn),
    .PCIn(PCIn), .MDRIn(MDRIn), .IRIn(IRIn), .YIn(YIn), .IncPC(IncPC), .HiIn(HiIn),
    .LoIn(LoIn), .CIn(CIn), .InIn(InIn), .OutIn(OutIn), .ZIn(ZIn), .CONIn(CONIn),
    .RIn(RIn), .Gra(Gra), .Grb(Grb), .Grc(Grc), .add(add), .subtract(subtract),
    .multiply(multiply), .divide(divide), .andSignal(andSignal), .orSignal(orSignal)
  );

  assign w_obs = {orSignal, andSignal, divide, multiply, subtract, add, Grc, Grb, Gra, RIn,
                  CONIn, ZIn, OutIn, InIn, CIn, LoIn, HiIn, IncPC, YIn, IRIn, MDRIn, PCIn,
                  MARIn, Rout, BAout, HIout, LOout, IN_Portout, Cout, MDRout, Zhighout,
                  Zlowout, PCout, write, read, run};

  function automatic vec_t mk(input logic [4:0] op, input logic con, input int len,
                              input logic [35:0] e3, input logic [35:0] e4,
                              input logic [35:0] e5, input logic [35:0] e6,
                              input logic [35:0] e7);
    vec_t v;
    v.ir      = {op, 27'($urandom)};
    v.con     = con;
    v.len     = 4'(len);
    v.tail[0] = e3;
    v.tail[1] = e4;
    v.tail[2] = e5;
    v.tail[3] = e6;
    v.tail[4] = e7;
    return v;
  endfunction

  task automatic check(input string nm, input logic [35:0] got, input logic [35:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Scoreboard drain: one queued expectation per falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) check(tag_q.pop_front(), w_obs, exp_q.pop_front());
  end

  task automatic expect_cycle(input logic [35:0] e, input logic [31:0] ir_v,
                              input logic con_v, input string nm);
    @(posedge clk);
    #1;
    ir     = ir_v;
    con_ff = con_v;
    exp_q.push_back(e);
    tag_q.push_back(nm);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [35:0] e;
    logic [31:0] iv;
    logic        cv;
    for (int c = 0; c < int'(v.len); c++) begin
      e  = (c == 0) ? F0 : (c == 1) ? F1 : (c == 2) ? F2 : v.tail[c-3];
      iv = (c < 3) ? $urandom : v.ir;
      cv = (c == 6) ? v.con : ~v.con;
      expect_cycle(e, iv, cv, $sformatf("vec%0d_T%0d", idx, c));
    end
  endtask

  initial begin
    vec_t ldv;
    #20000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t ldv;
    vec_t hv;
    vecs[0]  = mk(5'b00011, 1'b0, 6, M_RUN|M_GRB|M_ROUT|M_YIN, M_RUN|M_GRC|M_ROUT|M_ADD|M_ZIN,
                  M_RUN|M_ZLOW|M_GRA|M_RIN, 36'h0, 36'h0);
    vecs[0].ir = 32'h18A30000;
    vecs[1]  = mk(5'b00100, 1'b1, 6, M_RUN|M_GRB|M_ROUT|M_YIN, M_RUN|M_GRC|M_ROUT|M_SUB|M_ZIN,
                  M_RUN|M_ZLOW|M_GRA|M_RIN, 36'h0, 36'h0);
    vecs[2]  = mk(5'b00101, 1'b0, 6, M_RUN|M_GRB|M_ROUT|M_YIN, M_RUN|M_GRC|M_ROUT|M_AND|M_ZIN,
                  M_RUN|M_ZLOW|M_GRA|M_RIN, 36'h0, 36'h0);
    vecs[3]  = mk(5'b00110, 1'b1, 6, M_RUN|M_GRB|M_ROUT|M_YIN, M_RUN|M_GRC|M_ROUT|M_OR|M_ZIN,
                  M_RUN|M_ZLOW|M_GRA|M_RIN, 36'h0, 36'h0);
    vecs[4]  = mk(5'b01110, 1'b0, 7, M_RUN|M_GRA|M_ROUT|M_YIN, M_RUN|M_GRB|M_ROUT|M_MUL|M_ZIN,
                  M_RUN|M_ZLOW|M_LOIN, M_RUN|M_ZHIGH|M_HIIN, 36'h0);
    vecs[5]  = mk(5'b10111, 1'b0, 4, M_RUN|M_HIOUT|M_GRA|M_RIN, 36'h0, 36'h0, 36'h0, 36'h0);
    vecs[6]  = mk(5'b01111, 1'b1, 7, M_RUN|M_GRA|M_ROUT|M_YIN, M_RUN|M_GRB|M_ROUT|M_DIV|M_ZIN,
                  M_RUN|M_ZLOW|M_LOIN, M_RUN|M_ZHIGH|M_HIIN, 36'h0);
    vecs[7]  = mk(5'b11000, 1'b0, 4, M_RUN|M_LOOUT|M_GRA|M_RIN, 36'h0, 36'h0, 36'h0, 36'h0);
    vecs[8]  = mk(5'b00000, 1'b1, 8, M_RUN|M_GRB|M_BAOUT|M_YIN, M_RUN|M_COUT|M_ADD|M_ZIN,
                  M_RUN|M_ZLOW|M_MARIN, M_RUN|M_READ|M_MDRIN, M_RUN|M_MDROUT|M_GRA|M_RIN);
    vecs[9]  = mk(5'b10010, 1'b1, 7, M_RUN|M_GRA|M_ROUT|M_CONIN, M_RUN|M_PCOUT|M_YIN,
                  M_RUN|M_COUT|M_ADD|M_ZIN, M_RUN|M_ZLOW|M_PCIN, 36'h0);
    vecs[10] = mk(5'b10010, 1'b0, 7, M_RUN|M_GRA|M_ROUT|M_CONIN, M_RUN|M_PCOUT|M_YIN,
                  M_RUN|M_COUT|M_ADD|M_ZIN, M_RUN|M_ZLOW, 36'h0);
    vecs[11] = mk(5'b11001, 1'b1, 4, M_RUN, 36'h0, 36'h0, 36'h0, 36'h0);
    vecs[12] = mk(5'b00001, 1'b0, 4, M_RUN, 36'h0, 36'h0, 36'h0, 36'h0);

    ir = 32'h0;
    con_ff = 1'b0;
    clr = 1'b1;
    #2;
    check("reset_async", w_obs, 36'h0);
    for (int i = 0; i < 3; i++) expect_cycle(36'h0, $urandom, 1'b1, $sformatf("reset_hold%0d", i));
    clr = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // ld aborted by clr while in T5, asserted between edges.
    ldv = vecs[8];
    for (int c = 0; c < 6; c++)
      expect_cycle((c == 0) ? F0 : (c == 1) ? F1 : (c == 2) ? F2 : ldv.tail[c-3],
                   (c < 3) ? $urandom : ldv.ir, 1'b0, $sformatf("ldabort_T%0d", c));
    #6;
    clr = 1'b1;
    #1;
    check("ldabort_async_clr", w_obs, 36'h0);
    expect_cycle(36'h0, ldv.ir, 1'b0, "ldabort_reset");
    clr = 1'b0;

    // halt then absorbing HALT, then a short clr pulse restarts fetch.
    hv = mk(5'b11010, 1'b0, 4, M_RUN, 36'h0, 36'h0, 36'h0, 36'h0);
    run_vec(hv, 99);
    for (int i = 0; i < 20; i++) expect_cycle(36'h0, $urandom, 1'($urandom), $sformatf("halt%0d", i));
    #6;
    clr = 1'b1;
    #1;
    check("halt_clr_pulse", w_obs, 36'h0);
    #1;
    clr = 1'b0;
    expect_cycle(F0, $urandom, 1'b0, "restart_T0");
    expect_cycle(F1, $urandom, 1'b0, "restart_T1");
    expect_cycle(F2, $urandom, 1'b0, "restart_T2");
    @(posedge clk);
    #6;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
